goofy_io_port: RTL and testbench

Memory-mapped I/O bridge sitting directly downstream of the Goofy core's I/O read/write microcode strobes. It consumes single-cycle I/O write and read requests addressed by the core's 16-bit register-pair address. Write data is buffered in a small transmit FIFO that drains through an 8N1 serial transmitter. A one-byte receive holding register accepts bytes from a parallel valid/ready source for the core to read back.

---
 rtl/goofy_io_pkg.sv | 22 ++
 rtl/goofy_io_fifo.sv | 53 +++++
 rtl/goofy_io_port.sv | 169 ++++++++++++++++
 tb/tb_goofy_io_port.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/goofy_io_pkg.sv
// Shared definitions for the Goofy I/O port: register map, STATUS layout and
// serializer states.
package goofy_io_pkg;

   localparam logic [15:0] IO_TXDATA = 16'h0000;
   localparam logic [15:0] IO_STATUS = 16'h0001;
   localparam logic [15:0] IO_RXDATA = 16'h0002;

   localparam int ST_TX_FULL   = 0;
   localparam int ST_TX_EMPTY  = 1;
   localparam int ST_RX_AVAIL  = 2;
   localparam int ST_TX_ACTIVE = 3;
   localparam int ST_TX_OVF    = 4;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } ser_state_e;

endpackage

// File: rtl/goofy_io_fifo.sv
// Synchronous FIFO with a combinational head output. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module goofy_io_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     res,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // NOTE: the storage array is not reset; only pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/goofy_io_port.sv
// Memory-mapped I/O bridge: TXDATA pushes into a FIFO drained by an 8N1
// serializer; RXDATA returns a one-byte holding register fed by valid/ready.
module goofy_io_port
   import goofy_io_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        res,
   input  logic [15:0] io_addr,
   input  logic [7:0]  io_wdata,
   input  logic        io_we,
   input  logic        io_re,
   output logic [7:0]  io_rdata,
   output logic        tx,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   localparam int BW = $clog2(CLK_DIV);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   ser_state_e    state, state_nx;
   logic [BW-1:0] baud_cnt, baud_nx;
   logic [2:0]    bit_cnt, bit_nx;
   logic [7:0]    shreg, shreg_nx;
   logic          ser_pop;
   logic          baud_done;

   logic          wr_tx, rd_status, rd_rx;
   logic          push_ok, ovf_set;
   logic          tx_overflow;
   logic          rx_avail;
   logic [7:0]    rx_hold;
   logic [7:0]    status;

   assign wr_tx     = io_we && (io_addr == IO_TXDATA);
   assign rd_status = io_re && (io_addr == IO_STATUS);
   assign rd_rx     = io_re && (io_addr == IO_RXDATA);

   // A full FIFO still takes the byte when the serializer frees a slot this cycle.
   assign push_ok = (fifo_count < CW'(FIFO_DEPTH)) || ser_pop;
   assign ovf_set = wr_tx && !push_ok;

   goofy_io_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .res   (res),
      .push  (wr_tx && push_ok),
      .pop   (ser_pop),
      .din   (io_wdata),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign baud_done = (baud_cnt == BW'(CLK_DIV - 1));

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_nx = state;
      baud_nx  = baud_done ? '0 : baud_cnt + BW'(1);
      bit_nx   = bit_cnt;
      shreg_nx = shreg;
      ser_pop  = 1'b0;
      tx       = 1'b1;
      case (state)
         IDLE: begin
            baud_nx = '0;
            if (!fifo_empty) begin
               ser_pop  = 1'b1;
               shreg_nx = fifo_dout;
               state_nx = START;
            end
         end
         START: begin
            tx = 1'b0;
            if (baud_done) begin
               bit_nx   = '0;
               state_nx = DATA;
            end
         end
         DATA: begin
            tx = shreg[0];
            if (baud_done) begin
               shreg_nx = {1'b0, shreg[7:1]};
               bit_nx   = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nx = STOP;
            end
         end
         STOP: begin
            if (baud_done) begin
               if (!fifo_empty) begin
                  ser_pop  = 1'b1;
                  shreg_nx = fifo_dout;
                  state_nx = START;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments make every flop sample pre-edge values.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else begin
         state    <= state_nx;
         baud_cnt <= baud_nx;
         bit_cnt  <= bit_nx;
         shreg    <= shreg_nx;
      end
   end

   assign rx_ready = !rx_avail;

   always_comb begin
      status               = '0;
      status[ST_TX_FULL]   = fifo_full;
      status[ST_TX_EMPTY]  = fifo_empty;
      status[ST_RX_AVAIL]  = rx_avail;
      status[ST_TX_ACTIVE] = (state != IDLE);
      status[ST_TX_OVF]    = tx_overflow;
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         tx_overflow <= 1'b0;
         rx_avail    <= 1'b0;
         rx_hold     <= '0;
         io_rdata    <= '0;
      end else begin
         if (ovf_set)        tx_overflow <= 1'b1;
         else if (rd_status) tx_overflow <= 1'b0;

         if (rd_rx && rx_avail) begin
            rx_avail <= 1'b0;
         end else if (rx_valid && !rx_avail) begin
            rx_avail <= 1'b1;
            rx_hold  <= rx_data;
         end

         if (io_re) begin
            case (io_addr)
               IO_STATUS: io_rdata <= status;
               IO_RXDATA: io_rdata <= rx_avail ? rx_hold : 8'h00;
               default:   io_rdata <= 8'h00;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_goofy_io_port.sv
// Bench for goofy_io_port: register vector table, hand-written frame/reset
// sequences, then random traffic against a frame-timeline reference model.
module tb_goofy_io_port;

   localparam int D     = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * D;

   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic [15:0] io_addr = '0;
   logic [7:0]  io_wdata = '0;
   logic        io_we = 1'b0;
   logic        io_re = 1'b0;
   logic [7:0]  io_rdata;
   logic        tx;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   goofy_io_port #(
      .CLK_DIV    (D),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .res      (res),
      .io_addr  (io_addr),
      .io_wdata (io_wdata),
      .io_we    (io_we),
      .io_re    (io_re),
      .io_rdata (io_rdata),
      .tx       (tx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready)
   );

   // Reference model: queue of pending bytes plus a frame timeline position.
   logic [7:0] q[$];
   logic [7:0] m_byte;
   int         m_t;
   bit         m_busy;
   bit         m_ovf;
   bit         m_rx_avail;
   logic [7:0] m_rx_byte;
   logic [7:0] m_rdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic model_reset();
      q.delete();
      m_byte = '0; m_t = 0; m_busy = 0; m_ovf = 0;
      m_rx_avail = 0; m_rx_byte = '0; m_rdata = '0;
   endtask

   function automatic logic exp_tx();
      int idx;
      if (!m_busy) return 1'b1;
      idx = m_t / D;
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return m_byte[idx-1];
   endfunction

   task automatic model_edge(input logic we, input logic re, input logic [15:0] a,
                             input logic [7:0] wd, input logic rxv, input logic [7:0] rxd);
      bit pop_now, ovf_now, rx_pre;
      if (re) begin
         if (a == 16'h0001)
            m_rdata = {3'b000, m_ovf, m_busy, m_rx_avail, q.size() == 0, q.size() == DEPTH};
         else if (a == 16'h0002)
            m_rdata = m_rx_avail ? m_rx_byte : 8'h00;
         else
            m_rdata = 8'h00;
      end
      pop_now = (q.size() > 0) && (!m_busy || m_t == FRAME - 1);
      ovf_now = we && a == 16'h0000 && q.size() == DEPTH && !pop_now;
      if (m_busy) begin
         m_t++;
         if (m_t == FRAME) m_busy = 0;
      end
      if (pop_now) begin
         m_byte = q.pop_front();
         m_busy = 1;
         m_t    = 0;
      end
      if (we && a == 16'h0000 && !ovf_now) q.push_back(wd);
      if (ovf_now) m_ovf = 1;
      else if (re && a == 16'h0001) m_ovf = 0;
      rx_pre = m_rx_avail;
      if (re && a == 16'h0002 && rx_pre) m_rx_avail = 0;
      if (rxv && !rx_pre) begin
         m_rx_avail = 1;
         m_rx_byte  = rxd;
      end
   endtask

   task automatic cyc(input logic we, input logic re, input logic [15:0] a,
                      input logic [7:0] wd, input logic rxv, input logic [7:0] rxd);
      io_we = we; io_re = re; io_addr = a; io_wdata = wd; rx_valid = rxv; rx_data = rxd;
      @(posedge clk);
      model_edge(we, re, a, wd, rxv, rxd);
      #1;
      io_we = 1'b0; io_re = 1'b0; rx_valid = 1'b0;
      check("tx", tx, exp_tx());
      check("rx_ready", rx_ready, !m_rx_avail);
      check("io_rdata", io_rdata, m_rdata);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic read_status(input string name, input logic [7:0] exp);
      cyc(1'b0, 1'b1, 16'h0001, 8'h00, 1'b0, 8'h00);
      check(name, io_rdata, exp);
   endtask

   // Called just after a rising edge; drops reset between edges.
   task automatic do_reset();
      #2 res = 1'b0;
      #1;
      check("rst_tx", tx, 1'b1);
      check("rst_rx_ready", rx_ready, 1'b1);
      check("rst_rdata", io_rdata, 8'h00);
      model_reset();
      @(negedge clk);
      res = 1'b1;
   endtask

   typedef struct packed {
      logic        we;
      logic        re;
      logic [15:0] addr;
      logic [7:0]  wd;
      logic        rxv;
      logic [7:0]  rxd;
      logic [7:0]  exp_rdata;
      logic        exp_rdy;
   } vec_t;

   vec_t vt[13];
   bit   pat[10];

   initial begin
      vt[0]  = '{1'b0, 1'b1, 16'h0001, 8'h00, 1'b0, 8'h00, 8'h02, 1'b1};
      vt[1]  = '{1'b1, 1'b1, 16'h1234, 8'hAA, 1'b0, 8'h00, 8'h00, 1'b1};
      vt[2]  = '{1'b1, 1'b1, 16'h0001, 8'hFF, 1'b0, 8'h00, 8'h02, 1'b1};
      vt[3]  = '{1'b0, 1'b1, 16'h0001, 8'h00, 1'b0, 8'h00, 8'h02, 1'b1};
      vt[4]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hA7, 8'h02, 1'b0};
      vt[5]  = '{1'b0, 1'b1, 16'h0001, 8'h00, 1'b0, 8'h00, 8'h06, 1'b0};
      vt[6]  = '{1'b0, 1'b1, 16'h0002, 8'h00, 1'b0, 8'h00, 8'hA7, 1'b1};
      vt[7]  = '{1'b0, 1'b1, 16'h0002, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
      vt[8]  = '{1'b0, 1'b1, 16'h0002, 8'h00, 1'b1, 8'h3C, 8'h00, 1'b0};
      vt[9]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 8'h11, 8'h00, 1'b0};
      vt[10] = '{1'b0, 1'b1, 16'h0002, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b1};
      vt[11] = '{1'b1, 1'b1, 16'h0002, 8'h99, 1'b0, 8'h00, 8'h00, 1'b1};
      vt[12] = '{1'b0, 1'b1, 16'h0001, 8'h00, 1'b0, 8'h00, 8'h02, 1'b1};
      pat = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

      // Power-on reset
      model_reset();
      #3;
      check("por_tx", tx, 1'b1);
      check("por_rx_ready", rx_ready, 1'b1);
      check("por_rdata", io_rdata, 8'h00);
      @(negedge clk);
      res = 1'b1;

      // Register map vectors
      for (int i = 0; i < 13; i++) begin
         cyc(vt[i].we, vt[i].re, vt[i].addr, vt[i].wd, vt[i].rxv, vt[i].rxd);
         check($sformatf("vec%0d_rdata", i), io_rdata, vt[i].exp_rdata);
         check($sformatf("vec%0d_rx_ready", i), rx_ready, vt[i].exp_rdy);
      end

      // Single 0x55 frame with exact bit timing
      cyc(1'b1, 1'b0, 16'h0000, 8'h55, 1'b0, 8'h00);
      check("tx_before_pop", tx, 1'b1);
      for (int k = 0; k < FRAME; k++) begin
         idle();
         check($sformatf("frame55_c%0d", k), tx, pat[k / D]);
      end
      idle();
      check("frame55_idle", tx, 1'b1);
      read_status("st_after_frame", 8'h02);

      // Six back-to-back writes: one pops, four queue, one dropped
      for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 16'h0000, 8'(i), 1'b0, 8'h00);
      read_status("st_ovf_set", 8'h19);
      read_status("st_ovf_clr", 8'h09);
      for (int k = 0; k < 6 * FRAME && (m_busy || q.size() > 0); k++) idle();
      idle();
      read_status("st_after_burst", 8'h02);

      // Push into a full FIFO on the STOP->START pop edge
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'h0000, 8'hA0 + 8'(i), 1'b0, 8'h00);
      for (int k = 0; k < 2 * FRAME && !(m_busy && m_t == FRAME - 1); k++) idle();
      check("at_stop_end", tx, 1'b1);
      cyc(1'b1, 1'b0, 16'h0000, 8'hBB, 1'b0, 8'h00);
      check("pop_edge_start", tx, 1'b0);
      read_status("st_full_pop_push", 8'h09);
      for (int k = 0; k < 6 * FRAME && (m_busy || q.size() > 0); k++) idle();

      // Reset in the middle of DATA bit 3 (bit 3 of 0xF7 is 0)
      do_reset();
      cyc(1'b1, 1'b0, 16'h0000, 8'hF7, 1'b0, 8'h00);
      for (int k = 0; k < 4 * D + 2; k++) idle();
      check("bit3_low", tx, 1'b0);
      do_reset();
      for (int k = 0; k < 12 * D; k++) begin
         idle();
         check("no_residual", tx, 1'b1);
      end
      read_status("st_after_reset", 8'h02);

      // Random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         logic        we, re, rxv;
         logic [15:0] a;
         int          sel;
         we  = ($urandom_range(0, 99) < 6);
         re  = ($urandom_range(0, 3) == 0);
         rxv = ($urandom_range(0, 2) == 0);
         sel = $urandom_range(0, 4);
         a   = (sel < 3) ? 16'(sel) : 16'($urandom);
         cyc(we, re, a, 8'($urandom), rxv, 8'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
